uart_rx8051: RTL and testbench



---
 rtl/uart_rx8051.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx8051.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx8051.sv
// uart_rx8051 - 8051 serial port mode 1 receiver (8N1, LSB first, 16x oversampling).
// Presents SBUF / RI / RB8 semantics plus an overrun flag to the SFR block.
// Optional framing-error detection is enabled by defining UART_RX_FE_EN, which
// adds the fe output and suppresses loading of frames whose stop bit samples low.
module uart_rx8051 #(
    parameter int CLK_DIV     = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       ren,
    input  logic       ri_clr,
    output logic [7:0] sbuf,
    output logic       ri,
    output logic       rb8,
    output logic       ovr,
    output logic       busy
`ifdef UART_RX_FE_EN
    ,
    output logic       fe
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_d_q;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic                   tick;
    logic [3:0]             s_q;
    logic [3:0]             s_inc;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic                   samp7_q;
    logic                   samp8_q;
    logic                   maj;
    logic                   start_det;
    logic                   ri_eff;
    state_t                 state_q;
    logic [7:0]             sbuf_q;
    logic                   ri_q;
    logic                   rb8_q;
    logic                   ovr_q;
    logic                   busy_q;
`ifdef UART_RX_FE_EN
    logic                   fe_q;
`endif

    // rxd synchroniser chain; flops preset to idle-high so reset never looks like a start edge
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!rst) sync_q[gi] <= 1'b1;
                else      sync_q[gi] <= rxd;
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (!rst) sync_q[gi] <= 1'b1;
                else      sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // One-cycle delayed copy of the synchronised line for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) rxs_d_q <= 1'b1;
        else      rxs_d_q <= rxs;
    end

    assign start_det = (state_q == IDLE) && ren && rxs_d_q && !rxs;
    assign tick      = (cnt_q == DIV_M1);
    // Sample points are named by the count the tick advances s to, which puts
    // the stop-bit decision 153 ticks after the start edge independent of CLK_DIV.
    assign s_inc     = s_q + 4'd1;
    assign maj       = (samp7_q & samp8_q) | (samp7_q & rxs) | (samp8_q & rxs);
    assign ri_eff    = ri_q & ~ri_clr;

    // Prescaler next state: realigned to the start edge, otherwise wraps at CLK_DIV-1
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (start_det || tick) cnt_d = 8'd0;
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= cnt_d;
    end

    // Frame FSM with registered flags and the SBUF/RI/RB8/OVR load rule
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            samp7_q <= 1'b1;
            samp8_q <= 1'b1;
            sbuf_q  <= 8'd0;
            ri_q    <= 1'b0;
            rb8_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_FE_EN
            fe_q    <= 1'b0;
`endif
        end else begin
            // Software clear; a load later in this block overrides ri
            if (ri_clr) begin
                ri_q  <= 1'b0;
                ovr_q <= 1'b0;
`ifdef UART_RX_FE_EN
                fe_q  <= 1'b0;
`endif
            end

            if (state_q == IDLE) begin
                busy_q <= 1'b0;
                if (start_det) begin
                    state_q <= START;
                    busy_q  <= 1'b1;
                    s_q     <= 4'd0;
                end
            end else if (!ren) begin
                // Receiver disabled mid-frame: drop the frame silently
                state_q <= IDLE;
                busy_q  <= 1'b0;
                s_q     <= 4'd0;
            end else if (tick) begin
                s_q <= s_inc;
                if (s_inc == 4'd7) samp7_q <= rxs;
                if (s_inc == 4'd8) samp8_q <= rxs;
                case (state_q)
                    START: begin
                        if (s_inc == 4'd9 && maj) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            s_q     <= 4'd0;
                        end else if (s_inc == 4'd15) begin
                            state_q <= DATA;
                            bit_q   <= 3'd0;
                        end
                    end
                    DATA: begin
                        if (s_inc == 4'd9) shift_q <= {maj, shift_q[7:1]};
                        if (s_inc == 4'd15) begin
                            if (bit_q == 3'd7) state_q <= STOP;
                            else               bit_q   <= bit_q + 3'd1;
                        end
                    end
                    STOP: begin
                        if (s_inc == 4'd9) begin
`ifdef UART_RX_FE_EN
                            if (!maj) begin
                                fe_q <= 1'b1;
                            end else if (ri_eff) begin
                                ovr_q <= 1'b1;
                            end else begin
                                sbuf_q <= shift_q;
                                rb8_q  <= maj;
                                ri_q   <= 1'b1;
                            end
`else
                            if (ri_eff) begin
                                ovr_q <= 1'b1;
                            end else begin
                                sbuf_q <= shift_q;
                                rb8_q  <= maj;
                                ri_q   <= 1'b1;
                            end
`endif
                            // Release half a bit early so a back-to-back start edge is caught
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            s_q     <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sbuf = sbuf_q;
    assign ri   = ri_q;
    assign rb8  = rb8_q;
    assign ovr  = ovr_q;
    assign busy = busy_q;
`ifdef UART_RX_FE_EN
    assign fe   = fe_q;
`endif

endmodule

// File: tb/tb_uart_rx8051.sv
// tb_uart_rx8051 - scoreboard bench for uart_rx8051 at CLK_DIV=2 (32 clk per bit).
// Build with UART_RX_FE_EN defined to exercise the framing-error variant.
module tb_uart_rx8051;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ren;
    logic       ri_clr;
    logic [7:0] sbuf;
    logic       ri;
    logic       rb8;
    logic       ovr;
    logic       busy;
`ifdef UART_RX_FE_EN
    logic       fe;
`endif

    typedef struct {
        logic [7:0] sbuf;
        logic       ri;
        logic       rb8;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    uart_rx8051 #(.CLK_DIV(2), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .ren    (ren),
        .ri_clr (ri_clr),
        .sbuf   (sbuf),
        .ri     (ri),
        .rb8    (rb8),
        .ovr    (ovr),
        .busy   (busy)
`ifdef UART_RX_FE_EN
        ,
        .fe     (fe)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Drives one 8N1 frame plus one idle bit; called and returns at a negedge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic pulse_ri_clr();
        ri_clr = 1'b1;
        @(negedge clk);
        ri_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; rxd = 1'b1; ren = 1'b1; ri_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (sbuf !== 8'h00) begin bad++; $display("FAIL reset_sbuf got=%h want=00", sbuf); end
        total++; if (ri !== 1'b0)    begin bad++; $display("FAIL reset_ri got=%b want=0", ri); end
        total++; if (rb8 !== 1'b0)   begin bad++; $display("FAIL reset_rb8 got=%b want=0", rb8); end
        total++; if (ovr !== 1'b0)   begin bad++; $display("FAIL reset_ovr got=%b want=0", ovr); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef UART_RX_FE_EN
        total++; if (fe !== 1'b0)    begin bad++; $display("FAIL reset_fe got=%b want=0", fe); end
`endif
        $display("reset: sbuf=%h ri=%b rb8=%b ovr=%b busy=%b", sbuf, ri, rb8, ovr, busy);
    endtask

    task automatic test_basic();
        int lat;
        lat = 0;
        sb_q.push_back('{sbuf: 8'hA5, ri: 1'b1, rb8: 1'b1, ovr: 1'b0});
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 11 * BIT_CLK; i++) begin
                    @(negedge clk);
                    if (ri === 1'b1 && lat == 0) lat = i;
                end
            end
        join
        e = sb_q.pop_front();
        // 2 sync flops + edge-detect register, then 153 ticks of 2 clk (+/-1)
        total++; if (lat < 305 || lat > 312) begin bad++; $display("FAIL basic_latency got=%0d want=305..312", lat); end
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL basic_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL basic_ri got=%b want=%b", ri, e.ri); end
        total++; if (rb8 !== e.rb8)   begin bad++; $display("FAIL basic_rb8 got=%b want=%b", rb8, e.rb8); end
        total++; if (ovr !== e.ovr)   begin bad++; $display("FAIL basic_ovr got=%b want=%b", ovr, e.ovr); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
        $display("basic: byte=A5 lat=%0d sbuf=%h ri=%b rb8=%b ovr=%b", lat, sbuf, ri, rb8, ovr);
    endtask

    task automatic test_overrun();
        sb_q.push_back('{sbuf: 8'hA5, ri: 1'b1, rb8: 1'b1, ovr: 1'b1});
        send_frame(8'h3C, 1'b1);
        e = sb_q.pop_front();
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL ovr_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL ovr_ri got=%b want=%b", ri, e.ri); end
        total++; if (ovr !== e.ovr)   begin bad++; $display("FAIL ovr_ovr got=%b want=%b", ovr, e.ovr); end
        $display("overrun: byte=3C sbuf=%h ri=%b ovr=%b", sbuf, ri, ovr);
        pulse_ri_clr();
        total++; if (ri !== 1'b0)  begin bad++; $display("FAIL ovr_clr_ri got=%b want=0", ri); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_clr_ovr got=%b want=0", ovr); end
        $display("ri_clr: ri=%b ovr=%b", ri, ovr);
        sb_q.push_back('{sbuf: 8'h3C, ri: 1'b1, rb8: 1'b1, ovr: 1'b0});
        send_frame(8'h3C, 1'b1);
        e = sb_q.pop_front();
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL reload_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL reload_ri got=%b want=%b", ri, e.ri); end
        total++; if (rb8 !== e.rb8)   begin bad++; $display("FAIL reload_rb8 got=%b want=%b", rb8, e.rb8); end
        total++; if (ovr !== e.ovr)   begin bad++; $display("FAIL reload_ovr got=%b want=%b", ovr, e.ovr); end
        $display("reload: byte=3C sbuf=%h ri=%b ovr=%b", sbuf, ri, ovr);
    endtask

    task automatic test_false_start();
        logic seen_hi;
        int   fall;
        pulse_ri_clr();
        seen_hi = 1'b0;
        fall    = 0;
        sb_q.push_back('{sbuf: 8'h3C, ri: 1'b0, rb8: 1'b1, ovr: 1'b0});
        rxd = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 6) rxd = 1'b1;
            if (busy === 1'b1) seen_hi = 1'b1;
            if (seen_hi && busy === 1'b0 && fall == 0) fall = i;
        end
        e = sb_q.pop_front();
        total++; if (seen_hi !== 1'b1) begin bad++; $display("FAIL false_busy_rise got=%b want=1", seen_hi); end
        total++; if (fall == 0 || fall > 26) begin bad++; $display("FAIL false_busy_fall got=%0d want=1..26", fall); end
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL false_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL false_ri got=%b want=%b", ri, e.ri); end
        $display("false_start: busy_fall=%0d sbuf=%h ri=%b", fall, sbuf, ri);
    endtask

    task automatic test_stop_zero();
`ifdef UART_RX_FE_EN
        sb_q.push_back('{sbuf: 8'h3C, ri: 1'b0, rb8: 1'b1, ovr: 1'b0});
`else
        sb_q.push_back('{sbuf: 8'h55, ri: 1'b1, rb8: 1'b0, ovr: 1'b0});
`endif
        send_frame(8'h55, 1'b0);
        e = sb_q.pop_front();
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL stop0_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL stop0_ri got=%b want=%b", ri, e.ri); end
        total++; if (rb8 !== e.rb8)   begin bad++; $display("FAIL stop0_rb8 got=%b want=%b", rb8, e.rb8); end
        total++; if (ovr !== e.ovr)   begin bad++; $display("FAIL stop0_ovr got=%b want=%b", ovr, e.ovr); end
`ifdef UART_RX_FE_EN
        total++; if (fe !== 1'b1) begin bad++; $display("FAIL stop0_fe got=%b want=1", fe); end
        pulse_ri_clr();
        total++; if (fe !== 1'b0) begin bad++; $display("FAIL stop0_fe_clr got=%b want=0", fe); end
`else
        pulse_ri_clr();
`endif
        $display("stop_zero: byte=55 sbuf=%h ri=%b rb8=%b", sbuf, ri, rb8);
    endtask

    task automatic test_ren_abort();
        logic [7:0] keep_sbuf;
        logic       seen;
`ifdef UART_RX_FE_EN
        keep_sbuf = 8'h3C;
`else
        keep_sbuf = 8'h55;
`endif
        sb_q.push_back('{sbuf: keep_sbuf, ri: 1'b0, rb8: 1'b0, ovr: 1'b0});
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (BIT_CLK + 3 * BIT_CLK + 16) @(negedge clk);
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b want=1", busy); end
                ren = 1'b0;
                @(negedge clk);
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_post got=%b want=0", busy); end
            end
        join
        e = sb_q.pop_front();
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL abort_ri got=%b want=%b", ri, e.ri); end
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL abort_sbuf got=%h want=%h", sbuf, e.sbuf); end
        $display("ren_abort: byte=FF busy=%b ri=%b sbuf=%h", busy, ri, sbuf);
        seen = 1'b0;
        sb_q.push_back('{sbuf: keep_sbuf, ri: 1'b0, rb8: 1'b0, ovr: 1'b0});
        fork
            send_frame(8'h12, 1'b1);
            begin
                for (int i = 0; i < 11 * BIT_CLK; i++) begin
                    @(negedge clk);
                    if (busy === 1'b1) seen = 1'b1;
                end
            end
        join
        e = sb_q.pop_front();
        total++; if (seen !== 1'b0)   begin bad++; $display("FAIL disabled_busy got=%b want=0", seen); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL disabled_ri got=%b want=%b", ri, e.ri); end
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL disabled_sbuf got=%h want=%h", sbuf, e.sbuf); end
        $display("ren_off: byte=12 busy_seen=%b ri=%b sbuf=%h", seen, ri, sbuf);
        ren = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        sb_q.push_back('{sbuf: 8'h5A, ri: 1'b1, rb8: 1'b1, ovr: 1'b0});
        send_frame(8'h5A, 1'b1);
        e = sb_q.pop_front();
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL pre_rst_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL pre_rst_ri got=%b want=%b", ri, e.ri); end
        // Partial frame: start bit, data bit0=1, then halfway into data bit1
        rxd = 1'b0; repeat (BIT_CLK) @(negedge clk);
        rxd = 1'b1; repeat (BIT_CLK) @(negedge clk);
        rxd = 1'b0; repeat (BIT_CLK / 2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        total++; if (sbuf !== 8'h00) begin bad++; $display("FAIL mid_rst_sbuf got=%h want=00", sbuf); end
        total++; if (ri !== 1'b0)    begin bad++; $display("FAIL mid_rst_ri got=%b want=0", ri); end
        total++; if (rb8 !== 1'b0)   begin bad++; $display("FAIL mid_rst_rb8 got=%b want=0", rb8); end
        total++; if (ovr !== 1'b0)   begin bad++; $display("FAIL mid_rst_ovr got=%b want=0", ovr); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        $display("mid_reset: sbuf=%h ri=%b rb8=%b ovr=%b busy=%b", sbuf, ri, rb8, ovr, busy);
        repeat (2 * BIT_CLK) @(negedge clk);
        sb_q.push_back('{sbuf: 8'h81, ri: 1'b1, rb8: 1'b1, ovr: 1'b0});
        send_frame(8'h81, 1'b1);
        e = sb_q.pop_front();
        total++; if (sbuf !== e.sbuf) begin bad++; $display("FAIL post_rst_sbuf got=%h want=%h", sbuf, e.sbuf); end
        total++; if (ri !== e.ri)     begin bad++; $display("FAIL post_rst_ri got=%b want=%b", ri, e.ri); end
        total++; if (rb8 !== e.rb8)   begin bad++; $display("FAIL post_rst_rb8 got=%b want=%b", rb8, e.rb8); end
        total++; if (ovr !== e.ovr)   begin bad++; $display("FAIL post_rst_ovr got=%b want=%b", ovr, e.ovr); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
        $display("post_reset: byte=81 sbuf=%h ri=%b rb8=%b", sbuf, ri, rb8);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_false_start();
        test_stop_zero();
        test_ren_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
